// File: rtl/tristate_bus_arbiter_if.sv
// Bus-side signal bundle for the tri-state bus arbiter.
// master: the arbiter, which drives ownership and enables.
// slave: the requester/driver side, which raises requests.
interface tristate_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         grant;
    logic [N_REQ-1:0]         drive_en;
    logic [$clog2(N_REQ)-1:0] owner;
    logic                     bus_busy;
    logic                     preempt;

    modport master (
        input  req,
        output grant,
        output drive_en,
        output owner,
        output bus_busy,
        output preempt
    );

    modport slave (
        output req,
        input  grant,
        input  drive_en,
        input  owner,
        input  bus_busy,
        input  preempt
    );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner sequencer for a shared three-state bus.
// Only one driver enable is high at a time. Between two owners there are
// exactly TA_CYCLES cycles with every enable low. An owner that keeps
// requesting for MAX_HOLD cycles is forced off the bus.
module tristate_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_HOLD  = 8,
    parameter int TA_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    tristate_bus_arbiter_if.master bus
);
    localparam int OW = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]       state,      state_nx;
    logic [7:0]       hold_cnt,   hold_nx;
    logic [2:0]       ta_cnt,     ta_nx;
    logic [OW-1:0]    last,       last_nx;
    logic [OW-1:0]    owner_r,    owner_nx;
    logic [N_REQ-1:0] grant_r,    grant_nx;
    logic             bus_busy_r, busy_nx;
    logic             preempt_r,  preempt_nx;

    logic             any_req;
    logic [OW-1:0]    winner;
    logic [N_REQ-1:0] winner_oh;
    logic             owner_req;
    logic             hold_max;
    logic             ta_done;
    logic             arb_now;

    // First set request bit scanning circularly upward from l+1.
    // N_REQ is a power of two, so the index addition wraps by itself.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    l);
        logic [OW-1:0] idx;
        logic [OW-1:0] pick;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = l + OW'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Arbitration inputs and per-state terminal conditions.
    always_comb begin
        any_req   = |bus.req;
        winner    = rr_pick(bus.req, last);
        winner_oh = N_REQ'(1) << winner;
        owner_req = bus.req[owner_r];
        hold_max  = (hold_cnt == 8'(MAX_HOLD));
        ta_done   = (ta_cnt == 3'(TA_CYCLES));
    end

    // Next-state logic: release handling in GRANT, gap counting in TURNAROUND,
    // and a shared arbitration step used from IDLE and the last gap cycle.
    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        ta_nx      = ta_cnt;
        last_nx    = last;
        owner_nx   = owner_r;
        grant_nx   = grant_r;
        busy_nx    = bus_busy_r;
        preempt_nx = 1'b0;
        arb_now    = 1'b0;

        case (state)
            ST_GRANT: begin
                if (!owner_req || hold_max) begin
                    // A voluntary drop wins over a simultaneous hold limit,
                    // so preempt only fires while the owner still requests.
                    state_nx   = ST_TURN;
                    grant_nx   = '0;
                    last_nx    = owner_r;
                    ta_nx      = 3'd1;
                    busy_nx    = 1'b1;
                    preempt_nx = owner_req;
                end else begin
                    hold_nx = hold_cnt + 8'd1;
                end
            end
            ST_TURN: begin
                if (ta_done) begin
                    arb_now = 1'b1;
                end else begin
                    ta_nx = ta_cnt + 3'd1;
                end
            end
            default: begin
                arb_now = 1'b1;
            end
        endcase

        if (arb_now) begin
            if (any_req) begin
                state_nx = ST_GRANT;
                grant_nx = winner_oh;
                owner_nx = winner;
                hold_nx  = 8'd1;
                busy_nx  = 1'b1;
            end else begin
                state_nx = ST_IDLE;
                grant_nx = '0;
                busy_nx  = 1'b0;
            end
        end
    end

    // State and registered outputs; reset leaves req[0] with first priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            ta_cnt     <= '0;
            last       <= OW'(N_REQ - 1);
            owner_r    <= '0;
            grant_r    <= '0;
            bus_busy_r <= 1'b0;
            preempt_r  <= 1'b0;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_nx;
            ta_cnt     <= ta_nx;
            last       <= last_nx;
            owner_r    <= owner_nx;
            grant_r    <= grant_nx;
            bus_busy_r <= busy_nx;
            preempt_r  <= preempt_nx;
        end
    end

    assign bus.grant    = grant_r;
    assign bus.drive_en = grant_r;
    assign bus.owner    = owner_r;
    assign bus.bus_busy = bus_busy_r;
    assign bus.preempt  = preempt_r;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter. Three instances cover the
// configurations the scenarios need: A (MAX_HOLD=8, TA=1), B (MAX_HOLD=2,
// TA=1) and C (MAX_HOLD=8, TA=3). A negedge monitor watches the bus-safety
// invariants on all three.
module tb_tristate_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   mon_en = 1'b0;

    logic [3:0] last_nz [3];
    int         zrun    [3];
    logic [3:0] rr_exp  [13];
    logic [3:0] exp_g;

    tristate_bus_arbiter_if #(.N_REQ(4)) ifa ();
    tristate_bus_arbiter_if #(.N_REQ(4)) ifb ();
    tristate_bus_arbiter_if #(.N_REQ(4)) ifc ();

    tristate_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TA_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa));
    tristate_bus_arbiter #(.N_REQ(4), .MAX_HOLD(2), .TA_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb));
    tristate_bus_arbiter #(.N_REQ(4), .MAX_HOLD(8), .TA_CYCLES(3)) dut_c (
        .clk(clk), .reset(reset), .bus(ifc));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle and settle just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants: enables mirror grant, at most one owner, and a change of
    // owner is preceded by at least ta zero-grant cycles.
    task automatic mon(input int i, input logic [3:0] g, input logic [3:0] de, input int ta);
        chk("drive_en_eq_grant", de, g);
        chk("grant_onehot0", $onehot0(g), 1);
        if (g == 4'b0000) begin
            zrun[i]++;
        end else begin
            if (last_nz[i] != 4'b0000 && g != last_nz[i])
                chk("ta_gap", zrun[i] >= ta, 1);
            last_nz[i] = g;
            zrun[i]    = 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, ifa.grant, ifa.drive_en, 1);
            mon(1, ifb.grant, ifb.drive_en, 1);
            mon(2, ifc.grant, ifc.drive_en, 3);
        end
    end

    initial begin
        reset   = 1'b1;
        ifa.req = 4'b1111;
        ifb.req = 4'b0000;
        ifc.req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            last_nz[i] = 4'b0000;
            zrun[i]    = 0;
        end
        rr_exp[0]  = 4'b0001; rr_exp[1]  = 4'b0001; rr_exp[2]  = 4'b0000;
        rr_exp[3]  = 4'b0010; rr_exp[4]  = 4'b0010; rr_exp[5]  = 4'b0000;
        rr_exp[6]  = 4'b0100; rr_exp[7]  = 4'b0100; rr_exp[8]  = 4'b0000;
        rr_exp[9]  = 4'b1000; rr_exp[10] = 4'b1000; rr_exp[11] = 4'b0000;
        rr_exp[12] = 4'b0001;

        // Reset held two cycles with every request raised.
        step();
        step();
        mon_en = 1'b1;
        chk("rst_grant",   ifa.grant,    4'b0000);
        chk("rst_busy",    ifa.bus_busy, 1'b0);
        chk("rst_preempt", ifa.preempt,  1'b0);
        chk("rst_owner",   ifa.owner,    2'd0);
        reset   = 1'b0;
        ifa.req = 4'b0000;
        repeat (3) begin
            step();
            chk("idle_grant", ifa.grant,    4'b0000);
            chk("idle_busy",  ifa.bus_busy, 1'b0);
        end

        // Single requester 2, dropping its request in cycle 4.
        ifa.req = 4'b0100;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c == 4) ifa.req = 4'b0000;
            chk("single_grant", ifa.grant, (c <= 4) ? 4'b0100 : 4'b0000);
            if (c <= 4) chk("single_owner", ifa.owner, 2'd2);
            chk("single_busy", ifa.bus_busy, (c <= 5) ? 1'b1 : 1'b0);
        end

        // Round robin with all requests held and MAX_HOLD=2.
        ifb.req = 4'b1111;
        for (int c = 0; c < 13; c++) begin
            step();
            chk("rr_grant",   ifb.grant,   rr_exp[c]);
            chk("rr_preempt", ifb.preempt, (rr_exp[c] == 4'b0000) ? 1'b1 : 1'b0);
        end
        ifb.req = 4'b0000;
        repeat (4) step();

        // Three-cycle turnaround: 0 releases in cycle 3 with 1 pending.
        ifc.req = 4'b0001;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 2) ifc.req = 4'b0011;
            if (c == 3) ifc.req = 4'b0010;
            if (c == 8) ifc.req = 4'b0000;
            if (c <= 3)                 exp_g = 4'b0001;
            else if (c == 7 || c == 8)  exp_g = 4'b0010;
            else                        exp_g = 4'b0000;
            chk("ta_drive_en", ifc.drive_en, exp_g);
            chk("ta_busy",     ifc.bus_busy, (c <= 11) ? 1'b1 : 1'b0);
            chk("ta_preempt",  ifc.preempt,  1'b0);
        end

        // Preempt fairness: 0 held through cycle 19, 3 requests cycles 3..12.
        ifa.req = 4'b0001;
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 3)  ifa.req[3] = 1'b1;
            if (c == 13) ifa.req[3] = 1'b0;
            if (c == 20) ifa.req[0] = 1'b0;
            if (c <= 8)                   exp_g = 4'b0001;
            else if (c >= 10 && c <= 13)  exp_g = 4'b1000;
            else if (c >= 15 && c <= 20)  exp_g = 4'b0001;
            else                          exp_g = 4'b0000;
            chk("fair_grant",   ifa.grant,   exp_g);
            chk("fair_preempt", ifa.preempt, (c == 9) ? 1'b1 : 1'b0);
        end

        // Reset while requester 1 owns the bus with hold count 5.
        ifa.req = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("rmg_grant", ifa.grant, 4'b0010);
        end
        reset = 1'b1;
        step();
        chk("rmg_rst_grant", ifa.grant,    4'b0000);
        chk("rmg_rst_en",    ifa.drive_en, 4'b0000);
        chk("rmg_rst_busy",  ifa.bus_busy, 1'b0);
        reset   = 1'b0;
        ifa.req = 4'b0011;
        step();
        chk("rmg_after_grant", ifa.grant, 4'b0001);
        chk("rmg_after_owner", ifa.owner, 2'd0);
        ifa.req = 4'b0000;
        repeat (3) step();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
